// File: rtl/dma_multichan_engine.sv
// Multi-channel single-mode DMA engine: per-channel address/count/mode registers, fixed/rotating DREQ arbitration, HRQ/HLDA handshake.
// Latency: one IDLE cycle + REQ (until hlda) + S1/S2/S3 per transfer; eop is driven in S3. DMA_AUTOINIT_EN enables mode bit3 autoinit reload.
// Backpressure: the bus owner stalls a transfer by withholding hlda in REQ; dropping the winner's dreq there abandons the request.
module dma_multichan_engine #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16,
    parameter int RA_W   = $clog2(4*NUM_CH+1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [RA_W-1:0]   reg_addr,
    input  logic [ADDR_W-1:0] reg_wdata,
    output logic [ADDR_W-1:0] reg_rdata,
    input  logic [NUM_CH-1:0] dreq,
    output logic [NUM_CH-1:0] dack,
    output logic              hrq,
    input  logic              hlda,
    output logic [ADDR_W-1:0] addr_out,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              io_rd,
    output logic              io_wr,
    output logic              eop,
    output logic [NUM_CH-1:0] tc_status
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [RA_W-1:0] GLOB_ADDR = RA_W'(4*NUM_CH);

    typedef enum logic [2:0] {IDLE, REQ, S1, S2, S3} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   win_q, win_d, prio_q, pick, shift;
    logic [CH_W:0]     sum;
    logic [ADDR_W-1:0] cur_addr [NUM_CH];
    logic [CNT_W-1:0]  cur_cnt  [NUM_CH];
    logic [NUM_CH-1:0] en_q, dir_q, dec_q;
`ifdef DMA_AUTOINIT_EN
    logic [ADDR_W-1:0] base_addr [NUM_CH];
    logic [CNT_W-1:0]  base_cnt  [NUM_CH];
    logic [NUM_CH-1:0] auto_q;
`endif
    logic              rot_q, dis_q;
    logic [NUM_CH-1:0] tc_q, tc_set, eligible, rot_vec, win_oh;
    logic              found, reg_we, glob_rd, tc_now;
    logic [ADDR_W-1:0] sel_addr, step_addr;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_dir;

    assign reg_we    = reg_wr && (state_q == IDLE);
    assign glob_rd   = reg_rd && (reg_addr == GLOB_ADDR);
    assign win_oh    = NUM_CH'(1) << win_q;
    assign sel_addr  = cur_addr[win_q];
    assign sel_cnt   = cur_cnt[win_q];
    assign sel_dir   = dir_q[win_q];
    assign step_addr = dec_q[win_q] ? sel_addr - 1'b1 : sel_addr + 1'b1;
    assign tc_now    = (state_q == S3) && (sel_cnt == '0);
    assign tc_set    = tc_now ? win_oh : '0;
    assign tc_status = tc_q;

    // Rotate the request vector so the current highest-priority channel sits at bit 0.
    always_comb begin
        eligible = dreq & en_q & {NUM_CH{~dis_q}};
        found    = |eligible;
        shift    = rot_q ? prio_q : '0;
        rot_vec  = NUM_CH'({eligible, eligible} >> shift);
        pick     = '0;
        sum      = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (rot_vec[i]) begin
                sum = {1'b0, shift} + (CH_W+1)'(i);
                if (sum >= (CH_W+1)'(NUM_CH))
                    sum = sum - (CH_W+1)'(NUM_CH);
                pick = sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        hrq      = 1'b0;
        dack     = '0;
        addr_out = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        eop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    state_d = REQ;
                end
            end
            REQ: begin
                hrq = 1'b1;
                if (!dreq[win_q])
                    state_d = IDLE;
                else if (hlda)
                    state_d = S1;
            end
            S1: begin
                hrq      = 1'b1;
                dack     = win_oh;
                addr_out = sel_addr;
                state_d  = S2;
            end
            S2: begin
                hrq      = 1'b1;
                dack     = win_oh;
                addr_out = sel_addr;
                mem_rd   = sel_dir;
                io_rd    = ~sel_dir;
                state_d  = S3;
            end
            S3: begin
                hrq      = 1'b1;
                dack     = win_oh;
                addr_out = sel_addr;
                io_wr    = sel_dir;
                mem_wr   = ~sel_dir;
                eop      = tc_now;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            win_q   <= '0;
            prio_q  <= '0;
            rot_q   <= 1'b0;
            dis_q   <= 1'b0;
            tc_q    <= '0;
            en_q    <= '0;
            dir_q   <= '0;
            dec_q   <= '0;
`ifdef DMA_AUTOINIT_EN
            auto_q  <= '0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                cur_addr[c]  <= '0;
                cur_cnt[c]   <= '0;
`ifdef DMA_AUTOINIT_EN
                base_addr[c] <= '0;
                base_cnt[c]  <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            // A TC landing in the same cycle as the clearing read survives.
            tc_q    <= (tc_q & ~{NUM_CH{glob_rd}}) | tc_set;
            if (state_q == S3 && rot_q)
                prio_q <= (win_q == CH_W'(NUM_CH-1)) ? '0 : win_q + 1'b1;
            if (reg_we && reg_addr == GLOB_ADDR) begin
                rot_q <= reg_wdata[0];
                dis_q <= reg_wdata[1];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (reg_we && reg_addr == RA_W'(4*c)) begin
                    cur_addr[c]  <= reg_wdata;
`ifdef DMA_AUTOINIT_EN
                    base_addr[c] <= reg_wdata;
`endif
                end
                if (reg_we && reg_addr == RA_W'(4*c+1)) begin
                    cur_cnt[c]  <= reg_wdata[CNT_W-1:0];
`ifdef DMA_AUTOINIT_EN
                    base_cnt[c] <= reg_wdata[CNT_W-1:0];
`endif
                end
                if (reg_we && reg_addr == RA_W'(4*c+2)) begin
                    en_q[c]   <= reg_wdata[0];
                    dir_q[c]  <= reg_wdata[1];
                    dec_q[c]  <= reg_wdata[2];
`ifdef DMA_AUTOINIT_EN
                    auto_q[c] <= reg_wdata[3];
`endif
                end
                if (state_q == S3 && win_q == CH_W'(c)) begin
                    if (!tc_now) begin
                        cur_addr[c] <= step_addr;
                        cur_cnt[c]  <= cur_cnt[c] - 1'b1;
                    end
`ifdef DMA_AUTOINIT_EN
                    else if (auto_q[c]) begin
                        cur_addr[c] <= base_addr[c];
                        cur_cnt[c]  <= base_cnt[c];
                    end
`endif
                    else begin
                        cur_addr[c] <= step_addr;
                        cur_cnt[c]  <= '1;
                        en_q[c]     <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reg_addr == RA_W'(4*c))
                reg_rdata = cur_addr[c];
            if (reg_addr == RA_W'(4*c+1))
`ifdef DMA_AUTOINIT_EN
                reg_rdata = ADDR_W'(base_cnt[c]);
`else
                reg_rdata = ADDR_W'(cur_cnt[c]);
`endif
            if (reg_addr == RA_W'(4*c+2))
`ifdef DMA_AUTOINIT_EN
                reg_rdata = ADDR_W'({auto_q[c], dec_q[c], dir_q[c], en_q[c]});
`else
                reg_rdata = ADDR_W'({1'b0, dec_q[c], dir_q[c], en_q[c]});
`endif
            if (reg_addr == RA_W'(4*c+3))
                reg_rdata = ADDR_W'(cur_cnt[c]);
        end
        if (reg_addr == GLOB_ADDR)
            reg_rdata = ADDR_W'(tc_q);
    end

endmodule

// File: tb/tb_dma_multichan_engine.sv
// Directed bench for dma_multichan_engine (NUM_CH=4, ADDR_W=16): register table plus transfer sequences.
module tb_dma_multichan_engine;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        reg_wr, reg_rd;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata, reg_rdata;
    logic [3:0]  dreq, dack, tc_status;
    logic        hrq, hlda;
    logic [15:0] addr_out;
    logic        mem_rd, mem_wr, io_rd, io_wr, eop;

    int n_cmp = 0;
    int n_err = 0;

    dma_multichan_engine dut (
        .CLK(CLK), .RESET(RESET),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .dreq(dreq), .dack(dack), .hrq(hrq), .hlda(hlda),
        .addr_out(addr_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .io_rd(io_rd), .io_wr(io_wr), .eop(eop), .tc_status(tc_status)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {hrq, dack, addr_out, mem_rd, mem_wr, io_rd, io_wr, eop}
    function automatic logic [25:0] obs();
        return {hrq, dack, addr_out, mem_rd, mem_wr, io_rd, io_wr, eop};
    endfunction

    task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [15:0] exp, input logic clr);
        reg_addr = a; reg_rd = clr;
        #1;
        chk(nm, reg_rdata, exp);
        if (clr) begin
            tick();
            reg_rd = 1'b0;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
        dreq = '0; hlda = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    // One transfer, starting with the engine in IDLE and the request already presented.
    task automatic xfer(input int ch, input logic [15:0] a, input logic dir, input logic last, input logic clr);
        logic [25:0] e;
        logic [3:0]  dk;
        for (int p = 0; p < 5; p++) begin
            dk = (p >= 2) ? (4'(1) << ch) : 4'b0;
            e = {(p >= 1), dk, (p >= 2) ? a : 16'h0,
                 (p == 3) && dir, (p == 4) && !dir, (p == 3) && !dir, (p == 4) && dir,
                 (p == 4) && last};
            if (clr && p == 4) begin
                reg_rd = 1'b1; reg_addr = 5'd16;
            end
            #1;
            chk($sformatf("xfer ch%0d @%h phase%0d", ch, a, p), obs(), e);
            tick();
            reg_rd = 1'b0;
        end
    endtask

    initial begin
        do_reset();
        chk("reset outputs", obs(), 26'h0);
        chk("reset tc_status", tc_status, 4'h0);

        vt[0]  = '{1'b0, 1'b0, 5'd4,  16'h0000, 16'h0000};
        vt[1]  = '{1'b1, 1'b0, 5'd4,  16'h1234, 16'h0000};
        vt[2]  = '{1'b0, 1'b0, 5'd4,  16'h0000, 16'h1234};
        vt[3]  = '{1'b1, 1'b0, 5'd5,  16'h0005, 16'h0000};
        vt[4]  = '{1'b0, 1'b0, 5'd7,  16'h0000, 16'h0005};
        vt[5]  = '{1'b0, 1'b0, 5'd5,  16'h0000, 16'h0005};
        vt[6]  = '{1'b1, 1'b0, 5'd6,  16'h000F, 16'h0000};
`ifdef DMA_AUTOINIT_EN
        vt[7]  = '{1'b0, 1'b0, 5'd6,  16'h0000, 16'h000F};
`else
        vt[7]  = '{1'b0, 1'b0, 5'd6,  16'h0000, 16'h0007};
`endif
        vt[8]  = '{1'b1, 1'b0, 5'd20, 16'hFFFF, 16'h0000};
        vt[9]  = '{1'b0, 1'b0, 5'd20, 16'h0000, 16'h0000};
        vt[10] = '{1'b0, 1'b0, 5'd3,  16'h0000, 16'h0000};
        vt[11] = '{1'b0, 1'b1, 5'd16, 16'h0000, 16'h0000};
        vt[12] = '{1'b1, 1'b0, 5'd0,  16'hBEEF, 16'h0000};
        vt[13] = '{1'b0, 1'b0, 5'd0,  16'h0000, 16'hBEEF};
        vt[14] = '{1'b0, 1'b0, 5'd4,  16'h0000, 16'h1234};

        for (int i = 0; i < 15; i++) begin
            reg_wr = vt[i].wr; reg_rd = vt[i].rd; reg_addr = vt[i].addr; reg_wdata = vt[i].wdata;
            #1;
            if (!vt[i].wr)
                chk($sformatf("regvec%0d rdata", i), reg_rdata, vt[i].exp);
            tick();
            reg_wr = 1'b0; reg_rd = 1'b0;
        end

        // Three incrementing mem->IO transfers on ch1.
        do_reset();
        wr_reg(5'd4, 16'h1000); wr_reg(5'd5, 16'd2); wr_reg(5'd6, 16'h0003);
        dreq = 4'b0010; hlda = 1'b1;
        xfer(1, 16'h1000, 1'b1, 1'b0, 1'b0);
        xfer(1, 16'h1001, 1'b1, 1'b0, 1'b0);
        xfer(1, 16'h1002, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ch1 idle after tc", obs(), 26'h0);
        chk("ch1 tc_status", tc_status, 4'b0010);
        rd_chk("ch1 mode after tc", 5'd6, 16'h0002, 1'b0);
        rd_chk("ch1 count wrapped", 5'd7, 16'hFFFF, 1'b0);
        rd_chk("ch1 addr after", 5'd4, 16'h1003, 1'b0);

        // Fixed priority; clearing read coincides with ch2's TC.
        do_reset();
        wr_reg(5'd0, 16'h0100); wr_reg(5'd1, 16'd0); wr_reg(5'd2, 16'h0001);
        wr_reg(5'd8, 16'h0200); wr_reg(5'd9, 16'd0); wr_reg(5'd10, 16'h0001);
        dreq = 4'b0101; hlda = 1'b1;
        xfer(0, 16'h0100, 1'b0, 1'b1, 1'b0);
        chk("fixed tc after ch0", tc_status, 4'b0001);
        xfer(2, 16'h0200, 1'b0, 1'b1, 1'b1);
        chk("tc survives clear", tc_status, 4'b0100);

        // Rotating priority.
        do_reset();
        wr_reg(5'd16, 16'h0001);
        wr_reg(5'd0, 16'h0100); wr_reg(5'd1, 16'd1); wr_reg(5'd2, 16'h0001);
        wr_reg(5'd8, 16'h0200); wr_reg(5'd9, 16'd0); wr_reg(5'd10, 16'h0001);
        dreq = 4'b0101; hlda = 1'b1;
        xfer(0, 16'h0100, 1'b0, 1'b0, 1'b0);
        xfer(2, 16'h0200, 1'b0, 1'b1, 1'b0);
        xfer(0, 16'h0101, 1'b0, 1'b1, 1'b0);
        chk("rotating tc_status", tc_status, 4'b0101);

        // Decrement wraps below zero.
        do_reset();
        wr_reg(5'd0, 16'h0000); wr_reg(5'd1, 16'd0); wr_reg(5'd2, 16'h0005);
        dreq = 4'b0001; hlda = 1'b1;
        xfer(0, 16'h0000, 1'b0, 1'b1, 1'b0);
        dreq = '0;
        rd_chk("dec addr wrap", 5'd0, 16'hFFFF, 1'b0);
        rd_chk("dec count wrap", 5'd3, 16'hFFFF, 1'b0);

        // Aborted request; a write attempted in REQ is dropped.
        do_reset();
        wr_reg(5'd12, 16'h0300); wr_reg(5'd13, 16'd5); wr_reg(5'd14, 16'h0001);
        dreq = 4'b1000;
        #1; chk("abort idle", obs(), 26'h0);
        tick();
        reg_wr = 1'b1; reg_addr = 5'd13; reg_wdata = 16'h0077;
        #1; chk("abort req1", obs(), 26'h1 << 25);
        tick();
        reg_wr = 1'b0; dreq = '0;
        #1; chk("abort req2", obs(), 26'h1 << 25);
        tick();
        chk("abort back idle", obs(), 26'h0);
        tick();
        chk("abort stays idle", obs(), 26'h0);
        rd_chk("abort count kept", 5'd15, 16'd5, 1'b0);
        rd_chk("abort addr kept", 5'd12, 16'h0300, 1'b0);
        chk("abort tc_status", tc_status, 4'h0);

        // Controller disable blocks arbitration until cleared.
        do_reset();
        wr_reg(5'd16, 16'h0002); wr_reg(5'd2, 16'h0001);
        dreq = 4'b0001; hlda = 1'b1;
        tick(); tick(); tick();
        chk("disabled no hrq", obs(), 26'h0);
        wr_reg(5'd16, 16'h0000);
        tick();
        chk("enabled hrq", obs(), 26'h1 << 25);

`ifdef DMA_AUTOINIT_EN
        do_reset();
        wr_reg(5'd8, 16'h0020); wr_reg(5'd9, 16'd1); wr_reg(5'd10, 16'h0009);
        dreq = 4'b0100; hlda = 1'b1;
        xfer(2, 16'h0020, 1'b0, 1'b0, 1'b0);
        xfer(2, 16'h0021, 1'b0, 1'b1, 1'b0);
        dreq = '0;
        rd_chk("auto addr reload", 5'd8, 16'h0020, 1'b0);
        rd_chk("auto count reload", 5'd11, 16'd1, 1'b0);
        rd_chk("auto still enabled", 5'd10, 16'h0009, 1'b0);
        rd_chk("auto tc read", 5'd16, 16'h0004, 1'b1);
        chk("auto tc cleared", tc_status, 4'h0);
        rd_chk("auto tc reread", 5'd16, 16'h0000, 1'b0);
`endif

        // Reset in S2.
        do_reset();
        wr_reg(5'd4, 16'h0040); wr_reg(5'd5, 16'd3); wr_reg(5'd6, 16'h0003);
        dreq = 4'b0010; hlda = 1'b1;
        tick(); tick(); tick();
        chk("pre-reset S2", obs(), {1'b1, 4'b0010, 16'h0040, 5'b10000});
        RESET = 1'b1;
        tick();
        chk("mid reset outputs", obs(), 26'h0);
        RESET = 1'b0; dreq = '0; hlda = 1'b0;
        chk("mid reset tc", tc_status, 4'h0);
        rd_chk("mid reset addr", 5'd4, 16'h0000, 1'b0);
        rd_chk("mid reset count", 5'd7, 16'h0000, 1'b0);
        rd_chk("mid reset mode", 5'd6, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
